ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter; counterpart of the keyboard receive path.

---
 rtl/ps2_host_tx.sv | 240 ++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx
// Host-to-device PS/2 transmitter. It sends one command byte per request,
// such as 0xED (set LEDs) or 0xFF (reset). It drives the open-drain PS/2
// clock and data pins through active-high pull-low enables. Completion with
// ACK is reported on tx_done_o. A missing ACK or a bus timeout is reported
// on tx_err_o.
//
// Ports
//   clk_i          board clock
//   rst_n_i        asynchronous reset, active low
//   tx_data_i      command byte, captured when tx_valid_i && tx_ready_o
//   tx_valid_i     request to send tx_data_i
//   tx_ready_o     high only in IDLE
//   tx_done_o      1-cycle pulse: frame finished and device ACKed
//   tx_err_o       1-cycle pulse: no ACK, or timeout
//   busy_o         high whenever not IDLE (the receiver ignores the bus while busy)
//   ps2_clk_i      raw PS/2 clock pin level (asynchronous)
//   ps2_data_i     raw PS/2 data pin level (asynchronous)
//   ps2_clk_oe_o   1 = pull PS/2 clock low
//   ps2_data_oe_o  1 = pull PS/2 data low
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | lines released, waiting for tx_valid_i
// INHIBIT  | clock held low, then one cycle with the start bit added
// REQ      | clock released, data low (request-to-send), waiting for the first fall
// SHIFT    | one bit per fall: D0..D7, parity, then stop (release)
// ACK      | the next fall samples the device ACK on data
// WAITIDLE | waiting for clock and data to both return high
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_done_o,
    output logic       tx_err_o,
    output logic       busy_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAITIDLE
    } state_e;

    localparam int unsigned TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam logic [TMR_W-1:0] INH_LOAD = TMR_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             clk_s;
    logic             data_s;
    logic             clk_filt_q;
    logic [FLT_W-1:0] flt_cnt_q;
    logic             fall;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [8:0]       sh_q, sh_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             timed;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // The synchronizers and the filter reset to the idle-high bus level,
    // so that leaving reset is not mistaken for a falling clock edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            flt_cnt_q   <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            if (clk_s == clk_filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_LAST) begin
                clk_filt_q <= clk_s;
                flt_cnt_q  <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    // True in the cycle in which the filter accepts a 1->0 change.
    assign fall = clk_filt_q && !clk_s && (flt_cnt_q == FLT_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            sh_q      <= '0;
            bitcnt_q  <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            sh_q      <= sh_d;
            bitcnt_q  <= bitcnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        sh_d      = sh_q;
        bitcnt_d  = bitcnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        timed     = (state_q == S_REQ) || (state_q == S_SHIFT) ||
                    (state_q == S_ACK) || (state_q == S_WAITIDLE);

        // The bus timeout restarts on every device clock fall.
        if (timed) begin
            if (fall) begin
                tmr_d = TO_LOAD;
            end else if (tmr_q != '0) begin
                tmr_d = tmr_q - 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid_i) begin
                    sh_d     = {~^tx_data_i, tx_data_i};
                    bitcnt_d = '0;
                    tmr_d    = INH_LOAD;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            // Device clock falls that collide with the inhibit are ignored.
            S_INHIBIT: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (!data_oe_q) begin
                    data_oe_d = 1'b1;
                end else begin
                    clk_oe_d = 1'b0;
                    tmr_d    = TO_LOAD;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (fall) begin
                    data_oe_d = ~sh_q[0];
                    sh_d      = {1'b0, sh_q[8:1]};
                    bitcnt_d  = 4'd1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (fall) begin
                    if (bitcnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end else begin
                        data_oe_d = ~sh_q[0];
                        sh_d      = {1'b0, sh_q[8:1]};
                        bitcnt_d  = bitcnt_q + 1'b1;
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    if (!data_s) begin
                        state_d = S_WAITIDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAITIDLE: begin
                if (clk_filt_q && data_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        // A timeout overrides everything else, including a pending done.
        if (timed && !fall && (tmr_q == '0)) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b1;
            state_d   = S_IDLE;
        end
    end

    assign tx_ready_o    = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign tx_done_o     = done_q;
    assign tx_err_o      = err_q;
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx. A behavioural PS/2 device drives the open-drain bus.
// A reference model predicts the bits on the line, the frame outcome and the
// inhibit timeline.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TO   = 400;
    localparam int FLT  = 8;
    localparam int HALF = 40;
    localparam int LAT  = 2 + FLT;   // pin change -> accepted fall (sync + filter)

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, busy, clk_oe, data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_pin, data_pin;

    assign clk_pin  = ~(clk_oe | dev_clk_low);
    assign data_pin = ~(data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FLT)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .tx_done_o    (tx_done),
        .tx_err_o     (tx_err),
        .busy_o       (busy),
        .ps2_clk_i    (clk_pin),
        .ps2_data_i   (data_pin),
        .ps2_clk_oe_o (clk_oe),
        .ps2_data_oe_o(data_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_parity(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2) == 0;
    endfunction

    // Per-cycle comparison against the model state
    bit model_idle = 1'b0;
    bit inh_chk = 1'b0;
    int cap_cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int last_err_cyc = 0;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;

    always @(negedge clk) begin : cmp
        int j;
        if (rst_n) begin
            check("ready_vs_busy", tx_ready, !busy);
            check("done_err_exclusive", tx_done && tx_err, 0);
            if (tx_done) begin
                done_cnt++;
                check("done_single_cycle", prev_done, 0);
            end
            if (tx_err) begin
                err_cnt++;
                last_err_cyc = cyc;
                check("err_single_cycle", prev_err, 0);
            end
            if (model_idle) begin
                check("idle_clk_oe", clk_oe, 0);
                check("idle_data_oe", data_oe, 0);
                check("idle_ready", tx_ready, 1);
            end
            if (inh_chk) begin
                j = cyc - cap_cyc;
                if (j < INH) begin
                    check("inhibit_clk_oe", clk_oe, 1);
                    check("inhibit_data_oe", data_oe, 0);
                end else if (j == INH) begin
                    check("start_clk_oe", clk_oe, 1);
                    check("start_data_oe", data_oe, 1);
                end else if (j == INH + 1) begin
                    check("req_clk_oe", clk_oe, 0);
                    check("req_data_oe", data_oe, 1);
                    inh_chk = 1'b0;
                end
            end
        end
        prev_done = tx_done;
        prev_err  = tx_err;
    end

    task automatic start_frame(input logic [7:0] d, input bit junk);
        @(posedge clk); #1;
        model_idle = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        cap_cyc = cyc;
        inh_chk = 1'b1;
        check("ready_drops", tx_ready, 0);
        if (junk) begin
            for (int i = 0; i < 5; i++) begin
                tx_data = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Device: wait for request-to-send, then clock up to stop_after falls.
    // rx[i] is the data level the device sampled on the rise after fall i+1.
    task automatic device_frame(input int stop_after, input bit ack, input bit glitch,
                                output logic [9:0] rx, output int last_fall);
        bit seen = 1'b0;
        rx = '0;
        last_fall = 0;
        for (int t = 0; t < INH + 50 && !seen; t++) begin
            @(posedge clk); #1;
            if (clk_pin && !data_pin) seen = 1'b1;
        end
        check("rts_seen", seen, 1);
        if (!seen) return;
        for (int k = 1; k <= 11 && k <= stop_after; k++) begin
            for (int h = 0; h < HALF; h++) begin
                @(posedge clk); #1;
                if (k == 11 && ack && h == HALF / 2) dev_data_low = 1'b1;
                if (glitch && k == 5 && h == 15) dev_clk_low = 1'b1;
                if (glitch && k == 5 && h == 15 + FLT - 1) dev_clk_low = 1'b0;
            end
            @(posedge clk); #1;
            dev_clk_low = 1'b1;
            last_fall = cyc;
            repeat (HALF) @(posedge clk);
            #1;
            if (k <= 10) rx[k-1] = data_pin;
            dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input bit glitch,
                             input bit junk, output logic [9:0] rx);
        int lf;
        int d0;
        int e0;
        bit got = 1'b0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_frame(d, junk);
        device_frame(11, ack, glitch, rx, lf);
        for (int t = 0; t < 200 && !got; t++) begin
            @(posedge clk); #6;
            if (done_cnt != d0 || err_cnt != e0) got = 1'b1;
        end
        check("outcome_seen", got, 1);
        check("data_bits", rx[7:0], d);
        check("parity_bit", rx[8], model_parity(d));
        check("stop_bit", rx[9], 1);
        check("done_count", done_cnt - d0, ack ? 1 : 0);
        check("err_count", err_cnt - e0, ack ? 0 : 1);
        if (!ack) begin
            check("err_clk_released", clk_oe, 0);
            check("err_data_released", data_oe, 0);
            check("err_ready", tx_ready, 1);
        end
        model_idle = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin : stim
        logic [9:0] rx;
        int lf;
        int ones;
        int e0;
        int d0;
        bit got;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        check("rst_clk_oe", clk_oe, 0);
        check("rst_data_oe", data_oe, 0);
        model_idle = 1'b1;

        // 0xED with ACK: D0..D7 = 1,0,1,1,0,1,1,1, parity 1, stop 1
        run_frame(8'hED, 1'b1, 1'b0, 1'b0, rx);
        check("ed_line_bits", rx, 10'h3ED);

        // 0x00: parity 1, odd number of ones over data+parity
        run_frame(8'h00, 1'b1, 1'b0, 1'b0, rx);
        check("zero_parity", rx[8], 1);
        ones = 0;
        for (int i = 0; i < 9; i++) ones += int'(rx[i]);
        check("zero_odd_ones", ones % 2, 1);

        // 0xFF without ACK -> error
        run_frame(8'hFF, 1'b0, 1'b0, 1'b0, rx);
        check("ff_parity", rx[8], 1);

        // Device stops after 4 falls -> timeout error
        e0 = err_cnt;
        d0 = done_cnt;
        start_frame(8'h5A, 1'b0);
        device_frame(4, 1'b0, 1'b0, rx, lf);
        check("to_first_bits", rx[3:0], 4'hA);
        got = 1'b0;
        for (int t = 0; t < TO + 200 && !got; t++) begin
            @(posedge clk); #6;
            if (err_cnt != e0) got = 1'b1;
        end
        check("to_err_seen", got, 1);
        check("to_latency", last_err_cyc - lf, LAT + TO);
        check("to_no_done", done_cnt - d0, 0);
        check("to_clk_released", clk_oe, 0);
        check("to_data_released", data_oe, 0);
        check("to_ready", tx_ready, 1);
        model_idle = 1'b1;
        repeat (5) @(posedge clk);

        // Reset mid-SHIFT: after fall 5, D4 of 0xE0 (0) is on the line
        start_frame(8'hE0, 1'b0);
        device_frame(5, 1'b0, 1'b0, rx, lf);
        repeat (20) @(posedge clk);
        #3;
        check("pre_rst_data_oe", data_oe, 1);
        check("pre_rst_clk_oe", clk_oe, 0);
        rst_n = 1'b0;
        #1;
        check("rst_async_clk_oe", clk_oe, 0);
        check("rst_async_data_oe", data_oe, 0);
        check("rst_async_ready", tx_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_idle = 1'b1;
        @(negedge clk);
        check("post_rst_ready", tx_ready, 1);
        run_frame(8'hF4, 1'b1, 1'b0, 1'b0, rx);

        // Short clock glitch during SHIFT must not advance the bit counter
        run_frame(8'($urandom), 1'b1, 1'b1, 1'b0, rx);

        // Random frames, random ACK, tx_valid held while busy
        for (int n = 0; n < 8; n++) begin
            run_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, rx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
